// File: rtl/ha_pkg.sv
// Shared definitions for the half-adder result collector: join-state
// encoding, result field layout and a helper to build the joined result.
package ha_pkg;

  typedef logic [1:0] join_state_t;

  localparam join_state_t ST_EMPTY      = 2'b00;
  localparam join_state_t ST_HAVE_SUM   = 2'b01;
  localparam join_state_t ST_HAVE_CARRY = 2'b10;
  localparam join_state_t ST_HAVE_BOTH  = 2'b11;

  localparam int RES_W     = 2;
  localparam int SUM_IDX   = 0;
  localparam int CARRY_IDX = 1;

  function automatic logic [RES_W-1:0] pack_result(input logic carry, input logic sum);
    logic [RES_W-1:0] r;
    r            = '0;
    r[SUM_IDX]   = sum;
    r[CARRY_IDX] = carry;
    return r;
  endfunction

endpackage

// File: rtl/ha_result_fifo.sv
// Result FIFO for the collector. Pointers carry one extra wrap bit so full
// and empty are told apart without an occupancy counter. The head output is
// forced to zero while empty so the result bus reads 0 out of reset.
module ha_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; both may move on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ha_result_collector.sv
// Joins the independent sum and carry streams of a half-adder stage into a
// single {carry,sum} result stream buffered by ha_result_fifo.
// Optional delivery statistics are built when HA_COLLECTOR_STATS_EN is
// defined; otherwise result_count and carry_count are constant zero.
//
// state      | meaning
// EMPTY      | nothing held, both inputs ready
// HAVE_SUM   | sum held, waiting for carry
// HAVE_CARRY | carry held, waiting for sum
// HAVE_BOTH  | pair held, pushed as soon as the FIFO has room
module ha_result_collector
  import ha_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_sum_tvalid,
  input  logic             s_sum_tdata,
  output logic             s_sum_tready,
  input  logic             s_carry_tvalid,
  input  logic             s_carry_tdata,
  output logic             s_carry_tready,
  output logic             m_res_tvalid,
  output logic [1:0]       m_res_tdata,
  input  logic             m_res_tready,
  output logic [CNT_W-1:0] result_count,
  output logic [CNT_W-1:0] carry_count
);

  join_state_t state;
  join_state_t state_nxt;
  logic        sum_q;
  logic        carry_q;
  logic        sum_xfer;
  logic        carry_xfer;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;

  // Readiness depends on state alone so it never combinationally follows valid.
  assign s_sum_tready   = (state == ST_EMPTY) || (state == ST_HAVE_CARRY);
  assign s_carry_tready = (state == ST_EMPTY) || (state == ST_HAVE_SUM);

  assign sum_xfer   = s_sum_tvalid && s_sum_tready;
  assign carry_xfer = s_carry_tvalid && s_carry_tready;

  // Full is sampled at cycle start, so a same-edge pop does not open room.
  assign fifo_push = (state == ST_HAVE_BOTH) && !fifo_full;

  assign m_res_tvalid = !fifo_empty;
  assign fifo_pop     = m_res_tvalid && m_res_tready;

  // Join FSM next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: begin
        if (sum_xfer && carry_xfer) state_nxt = ST_HAVE_BOTH;
        else if (sum_xfer)          state_nxt = ST_HAVE_SUM;
        else if (carry_xfer)        state_nxt = ST_HAVE_CARRY;
      end
      ST_HAVE_SUM: begin
        if (carry_xfer) state_nxt = ST_HAVE_BOTH;
      end
      ST_HAVE_CARRY: begin
        if (sum_xfer) state_nxt = ST_HAVE_BOTH;
      end
      ST_HAVE_BOTH: begin
        if (fifo_push) state_nxt = ST_EMPTY;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  // State register and held operand bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_EMPTY;
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (sum_xfer)   sum_q   <= s_sum_tdata;
      if (carry_xfer) carry_q <= s_carry_tdata;
    end
  end

  ha_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RES_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (pack_result(carry_q, sum_q)),
    .pop       (fifo_pop),
    .pop_data  (m_res_tdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef HA_COLLECTOR_STATS_EN
  logic [CNT_W-1:0] result_cnt_q;
  logic [CNT_W-1:0] carry_cnt_q;

  // Delivery statistics; counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_cnt_q <= '0;
      carry_cnt_q  <= '0;
    end else if (fifo_pop) begin
      result_cnt_q <= result_cnt_q + 1'b1;
      if (m_res_tdata[CARRY_IDX]) carry_cnt_q <= carry_cnt_q + 1'b1;
    end
  end

  assign result_count = result_cnt_q;
  assign carry_count  = carry_cnt_q;
`else
  assign result_count = '0;
  assign carry_count  = '0;
`endif

endmodule

// File: tb/tb_ha_result_collector.sv
// Directed bench for ha_result_collector (DEPTH=4, CNT_W=4). Counter
// expectations follow HA_COLLECTOR_STATS_EN as seen by this compile.
module tb_ha_result_collector;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_sum_tvalid = 1'b0;
  logic       s_sum_tdata = 1'b0;
  logic       s_sum_tready;
  logic       s_carry_tvalid = 1'b0;
  logic       s_carry_tdata = 1'b0;
  logic       s_carry_tready;
  logic       m_res_tvalid;
  logic [1:0] m_res_tdata;
  logic       m_res_tready = 1'b0;
  logic [3:0] result_count;
  logic [3:0] carry_count;

  int checks = 0;
  int errors = 0;
  int exp_res = 0;
  int exp_carry = 0;

  ha_result_collector #(.DEPTH(4), .CNT_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .s_sum_tvalid   (s_sum_tvalid),
    .s_sum_tdata    (s_sum_tdata),
    .s_sum_tready   (s_sum_tready),
    .s_carry_tvalid (s_carry_tvalid),
    .s_carry_tdata  (s_carry_tdata),
    .s_carry_tready (s_carry_tready),
    .m_res_tvalid   (m_res_tvalid),
    .m_res_tdata    (m_res_tdata),
    .m_res_tready   (m_res_tready),
    .result_count   (result_count),
    .carry_count    (carry_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef HA_COLLECTOR_STATS_EN
    return n % 16;
`else
    return 0;
`endif
  endfunction

  // Head must be valid with value v; ready is high so it pops on the next edge.
  task automatic check_head(input string tag, input logic [1:0] v);
    chk({tag, "_valid"}, m_res_tvalid, 1);
    chk({tag, "_data"}, m_res_tdata, v);
    exp_res++;
    if (v[1]) exp_carry++;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_result_count"}, result_count, cnt_exp(exp_res));
    chk({tag, "_carry_count"}, carry_count, cnt_exp(exp_carry));
  endtask

  // Present a full pair and hold it until both inputs take it on the same edge.
  task automatic send_pair(input logic c, input logic s);
    int n;
    s_sum_tvalid   = 1'b1;
    s_sum_tdata    = s;
    s_carry_tvalid = 1'b1;
    s_carry_tdata  = c;
    n = 0;
    while (!(s_sum_tready && s_carry_tready) && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $error("FAIL send_pair_timeout: observed no ready after %0d cycles expected ready", n);
    end
    step();
    s_sum_tvalid   = 1'b0;
    s_carry_tvalid = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_res_valid", m_res_tvalid, 0);
    chk("rst_mid_sum_ready", s_sum_tready, 1);
    chk("rst_mid_carry_ready", s_carry_tready, 1);
    chk("rst_mid_res_data", m_res_tdata, 0);
    exp_res = 0;
    exp_carry = 0;
    check_counts("rst_mid");
    step();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    step();
    step();
    chk("rst_sum_ready", s_sum_tready, 1);
    chk("rst_carry_ready", s_carry_tready, 1);
    chk("rst_res_valid", m_res_tvalid, 0);
    chk("rst_res_data", m_res_tdata, 0);
    check_counts("rst");
    reset = 1'b0;
    m_res_tready = 1'b1;
    step();

    // Sum=1, carry=0 on the same edge
    s_sum_tvalid = 1'b1; s_sum_tdata = 1'b1;
    s_carry_tvalid = 1'b1; s_carry_tdata = 1'b0;
    step();
    s_sum_tvalid = 1'b0; s_carry_tvalid = 1'b0;
    chk("t1_both_sum_ready", s_sum_tready, 0);
    chk("t1_both_carry_ready", s_carry_tready, 0);
    chk("t1_not_yet_valid", m_res_tvalid, 0);
    step();
    check_head("t1_head", 2'b01);
    chk("t1_empty_sum_ready", s_sum_tready, 1);
    chk("t1_empty_carry_ready", s_carry_tready, 1);
    step();
    chk("t1_drained", m_res_tvalid, 0);
    check_counts("t1");

    // Carry first, sum three cycles later
    s_carry_tvalid = 1'b1; s_carry_tdata = 1'b1;
    step();
    s_carry_tvalid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk("t2_carry_ready_low", s_carry_tready, 0);
      chk("t2_sum_ready_high", s_sum_tready, 1);
      if (k < 3) step();
    end
    s_sum_tvalid = 1'b1; s_sum_tdata = 1'b0;
    step();
    s_sum_tvalid = 1'b0;
    chk("t2_both_sum_ready", s_sum_tready, 0);
    chk("t2_not_yet_valid", m_res_tvalid, 0);
    step();
    check_head("t2_head", 2'b10);
    step();
    chk("t2_drained", m_res_tvalid, 0);

    // Sum first; a second sum offered while held must be ignored
    s_sum_tvalid = 1'b1; s_sum_tdata = 1'b1;
    step();
    s_sum_tdata = 1'b0;
    chk("t3_sum_ready_low", s_sum_tready, 0);
    chk("t3_carry_ready_high", s_carry_tready, 1);
    step();
    chk("t3_sum_still_held", s_sum_tready, 0);
    s_sum_tvalid = 1'b0;
    s_carry_tvalid = 1'b1; s_carry_tdata = 1'b1;
    step();
    s_carry_tvalid = 1'b0;
    chk("t3_both_carry_ready", s_carry_tready, 0);
    step();
    check_head("t3_head", 2'b11);
    step();
    chk("t3_drained", m_res_tvalid, 0);
    check_counts("t3");

    // Backpressure: four queued plus one held in HAVE_BOTH
    m_res_tready = 1'b0;
    send_pair(1'b0, 1'b1);
    send_pair(1'b1, 1'b0);
    send_pair(1'b1, 1'b1);
    send_pair(1'b0, 1'b0);
    send_pair(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("t4_stall_sum_ready", s_sum_tready, 0);
      chk("t4_stall_carry_ready", s_carry_tready, 0);
      chk("t4_stall_valid", m_res_tvalid, 1);
      chk("t4_stall_head_stable", m_res_tdata, 2'b01);
      step();
    end
    m_res_tready = 1'b1;
    check_head("t4_r1", 2'b01);
    step();
    chk("t4_full_start_blocks_push", s_sum_tready, 0);
    check_head("t4_r2", 2'b10);
    step();
    chk("t4_pushed_sum_ready", s_sum_tready, 1);
    chk("t4_pushed_carry_ready", s_carry_tready, 1);
    s_sum_tvalid = 1'b1; s_sum_tdata = 1'b0;
    s_carry_tvalid = 1'b1; s_carry_tdata = 1'b1;
    check_head("t4_r3", 2'b00 | 2'b11);
    step();
    s_sum_tvalid = 1'b0; s_carry_tvalid = 1'b0;
    chk("t4_sixth_held", s_carry_tready, 0);
    check_head("t4_r4", 2'b00);
    step();
    check_head("t4_r5", 2'b11);
    step();
    check_head("t4_r6", 2'b10);
    step();
    chk("t4_drained", m_res_tvalid, 0);
    check_counts("t4");

    // Reset while HAVE_SUM with two results queued
    m_res_tready = 1'b0;
    send_pair(1'b0, 1'b1);
    step();
    send_pair(1'b1, 1'b0);
    step();
    s_sum_tvalid = 1'b1; s_sum_tdata = 1'b1;
    step();
    s_sum_tvalid = 1'b0;
    chk("t5_have_sum", s_sum_tready, 0);
    chk("t5_queued", m_res_tvalid, 1);
    pulse_reset();
    m_res_tready = 1'b1;
    s_carry_tvalid = 1'b1; s_carry_tdata = 1'b1;
    step();
    s_carry_tvalid = 1'b0;
    chk("t5_fresh_carry_ready", s_carry_tready, 0);
    chk("t5_fresh_sum_ready", s_sum_tready, 1);
    chk("t5_fifo_discarded", m_res_tvalid, 0);
    s_sum_tvalid = 1'b1; s_sum_tdata = 1'b0;
    step();
    s_sum_tvalid = 1'b0;
    step();
    check_head("t5_head", 2'b10);
    step();
    chk("t5_drained", m_res_tvalid, 0);
    check_counts("t5");

    // Counter wrap: 17 results, 9 with carry, from a clean reset
    pulse_reset();
    m_res_tready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      logic c;
      logic s;
      c = (i < 9);
      s = i[0];
      send_pair(c, s);
      step();
      check_head("t6_head", {c, s});
      step();
    end
    chk("t6_drained", m_res_tvalid, 0);
    check_counts("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
